// File: rtl/vproc_cfg_unit.sv
// vproc_cfg_unit
//   Executes configuration pseudo-unit instructions: vsetvl/vsetvli/vsetivli
//   and the vector CSR read / read-modify-write operations. It holds the
//   architectural vtype, vl, vstart, vxrm and vxsat state, broadcasts it to
//   the dispatcher and the execution units, and returns one 32-bit result per
//   instruction to the scalar core.
//
//   op_mode_i layout (13 bits):
//     [12:9] csr_op   : 0 VSETVL, 1 VTYPE rd, 2 VL rd, 3 VLENB rd,
//                       4..6 VSTART wr/set/clr, 7..9 VXSAT wr/set/clr,
//                       10..12 VXRM wr/set/clr, 13..15 VCSR wr/set/clr
//     [8:7]   vsew    : 0 e8, 1 e16, 2 e32, 3 invalid
//     [6:4]   lmul    : 0..3 m1/m2/m4/m8, 4 invalid, 5 mf8, 6 mf4, 7 mf2
//     [3:2]   agnostic: {mask agnostic, tail agnostic}
//     [1]     vlmax   : vl becomes VLMAX (rs1 = x0, rd != x0)
//     [0]     keep_vl : vl keeps its value, clipped to new VLMAX
//
//   Ports
//     clk_i, async_rst_i              clock, asynchronous active-high reset
//     op_valid_i/op_ready_o           instruction handshake (ready only when idle)
//     op_id_i/op_mode_i/op_xval_i     instruction id, mode, AVL / CSR operand
//     commit_valid_i/id_i/kill_i      commit or kill of an in-flight id
//     units_busy_i                    older vector work still pending
//     vxsat_set_i                     saturation event from the datapath
//     res_valid_o/res_ready_i         result handshake to the scalar core
//     res_id_o/res_data_o             result id and value
//     vsew_o, lmul_o, vl_o, vill_o,
//     vstart_o, vxrm_o, vxsat_o       registered configuration state
module vproc_cfg_unit #(
   parameter int unsigned VREG_W = 128,
   parameter int unsigned ID_W   = 3
) (
   input  logic                        clk_i,
   input  logic                        async_rst_i,
   input  logic                        op_valid_i,
   output logic                        op_ready_o,
   input  logic [ID_W-1:0]             op_id_i,
   input  logic [12:0]                 op_mode_i,
   input  logic [31:0]                 op_xval_i,
   input  logic                        commit_valid_i,
   input  logic [ID_W-1:0]             commit_id_i,
   input  logic                        commit_kill_i,
   input  logic                        units_busy_i,
   input  logic                        vxsat_set_i,
   output logic                        res_valid_o,
   input  logic                        res_ready_i,
   output logic [ID_W-1:0]             res_id_o,
   output logic [31:0]                 res_data_o,
   output logic [1:0]                  vsew_o,
   output logic [2:0]                  lmul_o,
   output logic [$clog2(VREG_W):0]     vl_o,
   output logic                        vill_o,
   output logic [$clog2(VREG_W)-1:0]   vstart_o,
   output logic [1:0]                  vxrm_o,
   output logic                        vxsat_o
);

   localparam int unsigned VL_W = $clog2(VREG_W) + 1;
   localparam int unsigned VS_W = $clog2(VREG_W);

   localparam logic [3:0] OP_VSETVL  = 4'd0;
   localparam logic [3:0] OP_VTYPE   = 4'd1;
   localparam logic [3:0] OP_VL      = 4'd2;
   localparam logic [3:0] OP_VLENB   = 4'd3;
   localparam logic [3:0] OP_VSTART0 = 4'd4;
   localparam logic [3:0] OP_VSTART2 = 4'd6;
   localparam logic [3:0] OP_VXSAT0  = 4'd7;
   localparam logic [3:0] OP_VXSAT2  = 4'd9;
   localparam logic [3:0] OP_VXRM0   = 4'd10;
   localparam logic [3:0] OP_VXRM2   = 4'd12;
   localparam logic [3:0] OP_VCSR0   = 4'd13;

   localparam logic [1:0] VSEW_8   = 2'd0;
   localparam logic [2:0] LMUL_1   = 3'd0;
   localparam logic [1:0] VXRM_RNU = 2'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_COMMIT,
      ST_DRAIN,
      ST_EXEC,
      ST_RESULT
   } state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [12:0]         mode_q, mode_d;
   logic [31:0]         xval_q, xval_d;
   logic [ID_W-1:0]     res_id_q, res_id_d;
   logic [31:0]         res_data_q, res_data_d;
   logic                vill_q, vill_d;
   logic [1:0]          vsew_q, vsew_d;
   logic [2:0]          lmul_q, lmul_d;
   logic [1:0]          agn_q, agn_d;
   logic [VL_W-1:0]     vl_q, vl_d;
   logic [VS_W-1:0]     vstart_q, vstart_d;
   logic [1:0]          vxrm_q, vxrm_d;
   logic                vxsat_q, vxsat_d;

   // VLMAX = VLENB >> sew, scaled up by integer LMUL or down by fractional LMUL.
   function automatic logic [31:0] calc_vlmax(input logic [1:0] sew, input logic [2:0] lmul);
      logic [31:0] v;
      v = 32'(VREG_W / 8) >> sew;
      if (!lmul[2]) v = v << lmul[1:0];
      else          v = v >> (4'd8 - {1'b0, lmul});
      return v;
   endfunction

   function automatic logic vtype_legal(input logic [1:0] sew, input logic [2:0] lmul);
      logic ok;
      ok = 1'b1;
      if (sew == 2'd3)                   ok = 1'b0;
      if (lmul == 3'd4 || lmul == 3'd5)  ok = 1'b0;
      if (lmul == 3'd6 && sew > 2'd0)    ok = 1'b0;
      if (lmul == 3'd7 && sew > 2'd1)    ok = 1'b0;
      return ok;
   endfunction

   // kind: 0 write, 1 set, 2 clear
   function automatic logic [31:0] csr_rmw(input logic [1:0] kind, input logic [31:0] old,
                                           input logic [31:0] x);
      logic [31:0] r;
      case (kind)
         2'd1:    r = old | x;
         2'd2:    r = old & ~x;
         default: r = x;
      endcase
      return r;
   endfunction

   logic [3:0]  m_op;
   logic [1:0]  m_sew;
   logic [2:0]  m_lmul;
   logic [1:0]  m_agn;
   logic        m_vlmax;
   logic        m_keep;
   logic [31:0] new_vlmax;
   logic [31:0] avl;
   logic [31:0] new_vl;
   logic [31:0] rmw_new;
   logic [31:0] rmw_old;
   logic [1:0]  rmw_kind;

   assign m_op    = mode_q[12:9];
   assign m_sew   = mode_q[8:7];
   assign m_lmul  = mode_q[6:4];
   assign m_agn   = mode_q[3:2];
   assign m_vlmax = mode_q[1];
   assign m_keep  = mode_q[0];

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      mode_d     = mode_q;
      xval_d     = xval_q;
      res_id_d   = res_id_q;
      res_data_d = res_data_q;
      vill_d     = vill_q;
      vsew_d     = vsew_q;
      lmul_d     = lmul_q;
      agn_d      = agn_q;
      vl_d       = vl_q;
      vstart_d   = vstart_q;
      vxrm_d     = vxrm_q;
      // Saturation events accumulate in every state; an explicit write below overrides.
      vxsat_d    = vxsat_q | vxsat_set_i;

      new_vlmax  = calc_vlmax(m_sew, m_lmul);
      avl        = m_keep ? 32'(vl_q) : xval_q;
      new_vl     = m_vlmax ? new_vlmax : ((avl < new_vlmax) ? avl : new_vlmax);

      // RMW CSR ops come in groups of three (write, set, clear) starting at op 4.
      rmw_kind   = 2'((m_op - 4'd4) % 4'd3);
      rmw_old    = 32'd0;
      if (m_op >= OP_VSTART0 && m_op <= OP_VSTART2)    rmw_old = 32'(vstart_q);
      else if (m_op >= OP_VXSAT0 && m_op <= OP_VXSAT2) rmw_old = {31'd0, vxsat_q};
      else if (m_op >= OP_VXRM0 && m_op <= OP_VXRM2)   rmw_old = {30'd0, vxrm_q};
      else if (m_op >= OP_VCSR0)                       rmw_old = {29'd0, vxrm_q, vxsat_q};
      rmw_new    = csr_rmw(rmw_kind, rmw_old, xval_q);

      case (state_q)
         ST_IDLE: begin
            if (op_valid_i) begin
               id_d    = op_id_i;
               mode_d  = op_mode_i;
               xval_d  = op_xval_i;
               state_d = ST_WAIT_COMMIT;
            end
         end
         ST_WAIT_COMMIT: begin
            if (commit_valid_i && commit_id_i == id_q) begin
               state_d = commit_kill_i ? ST_IDLE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // CSR state must not change under instructions that are still executing.
            if (!units_busy_i) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            res_id_d = id_q;
            state_d  = ST_RESULT;
            case (m_op)
               OP_VSETVL: begin
                  vstart_d = '0;
                  if (vtype_legal(m_sew, m_lmul)) begin
                     vill_d     = 1'b0;
                     vsew_d     = m_sew;
                     lmul_d     = m_lmul;
                     agn_d      = m_agn;
                     vl_d       = new_vl[VL_W-1:0];
                     res_data_d = new_vl;
                  end else begin
                     vill_d     = 1'b1;
                     vsew_d     = VSEW_8;
                     lmul_d     = LMUL_1;
                     agn_d      = 2'b00;
                     vl_d       = '0;
                     res_data_d = 32'd0;
                  end
               end
               OP_VTYPE: res_data_d = {vill_q, 23'd0, agn_q[1], agn_q[0], 1'b0, vsew_q, lmul_q};
               OP_VL:    res_data_d = 32'(vl_q);
               OP_VLENB: res_data_d = 32'(VREG_W / 8);
               default: begin
                  res_data_d = rmw_old;
                  if (m_op <= OP_VSTART2)     vstart_d = rmw_new[VS_W-1:0];
                  else if (m_op <= OP_VXSAT2) vxsat_d  = rmw_new[0];
                  else if (m_op <= OP_VXRM2)  vxrm_d   = rmw_new[1:0];
                  else begin
                     vxrm_d  = rmw_new[2:1];
                     vxsat_d = rmw_new[0];
                  end
               end
            endcase
         end
         ST_RESULT: begin
            if (res_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         state_q    <= ST_IDLE;
         id_q       <= '0;
         mode_q     <= '0;
         xval_q     <= '0;
         res_id_q   <= '0;
         res_data_q <= '0;
         vill_q     <= 1'b1;
         vsew_q     <= VSEW_8;
         lmul_q     <= LMUL_1;
         agn_q      <= 2'b00;
         vl_q       <= '0;
         vstart_q   <= '0;
         vxrm_q     <= VXRM_RNU;
         vxsat_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         mode_q     <= mode_d;
         xval_q     <= xval_d;
         res_id_q   <= res_id_d;
         res_data_q <= res_data_d;
         vill_q     <= vill_d;
         vsew_q     <= vsew_d;
         lmul_q     <= lmul_d;
         agn_q      <= agn_d;
         vl_q       <= vl_d;
         vstart_q   <= vstart_d;
         vxrm_q     <= vxrm_d;
         vxsat_q    <= vxsat_d;
      end
   end

   assign op_ready_o  = (state_q == ST_IDLE);
   assign res_valid_o = (state_q == ST_RESULT);
   assign res_id_o    = res_id_q;
   assign res_data_o  = res_data_q;
   assign vsew_o      = vsew_q;
   assign lmul_o      = lmul_q;
   assign vl_o        = vl_q;
   assign vill_o      = vill_q;
   assign vstart_o    = vstart_q;
   assign vxrm_o      = vxrm_q;
   assign vxsat_o     = vxsat_q;

endmodule
